// File: rtl/clk_enable_gen.sv
// Phase-accumulator clock-enable generator gated by a synchronized PLL lock flag.
// Each channel emits single-cycle enable pulses at f_refclk*inc/2^DIV_WIDTH plus a toggling clock.
module clk_enable_gen #(
  parameter int unsigned NUM_CLOCKS  = 2,
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned LOCK_COUNT  = 1024,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                             refclk,
  input  logic                             rst,
  input  logic                             pll_locked,
  input  logic [NUM_CLOCKS*DIV_WIDTH-1:0]  cfg_inc,
  input  logic [NUM_CLOCKS*DIV_WIDTH-1:0]  cfg_phase,
  input  logic                             cfg_load,
  output logic [NUM_CLOCKS-1:0]            outclk_en,
  output logic [NUM_CLOCKS-1:0]            outclk,
  output logic                             locked
);

  localparam int unsigned CntW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {StUnlocked, StSettle, StRun} state_e;

  state_e                          state;
  logic [CntW-1:0]                 cnt;
  logic [SYNC_STAGES-1:0]          sync;
  logic                            lock_s;
  logic [NUM_CLOCKS*DIV_WIDTH-1:0] sh_inc;
  logic [NUM_CLOCKS*DIV_WIDTH-1:0] sh_phase;
  logic [DIV_WIDTH-1:0]            acc [NUM_CLOCKS];
  logic [DIV_WIDTH:0]              sum [NUM_CLOCKS];

  assign lock_s = sync[SYNC_STAGES-1];

  // Carry out of the extra top bit is the enable pulse for that channel.
  always_comb begin
    for (int n = 0; n < NUM_CLOCKS; n++) begin
      sum[n] = {1'b0, acc[n]} + {1'b0, sh_inc[n*DIV_WIDTH +: DIV_WIDTH]};
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= StUnlocked;
      cnt       <= '0;
      sync      <= '0;
      outclk_en <= '0;
      outclk    <= '0;
      locked    <= 1'b0;
      sh_inc    <= '0;
      sh_phase  <= '0;
      for (int n = 0; n < NUM_CLOCKS; n++) begin
        acc[n] <= '0;
      end
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pll_locked};
      if (cfg_load) begin
        sh_inc   <= cfg_inc;
        sh_phase <= cfg_phase;
      end
      unique case (state)
        StUnlocked: begin
          cnt       <= '0;
          locked    <= 1'b0;
          outclk_en <= '0;
          outclk    <= '0;
          for (int n = 0; n < NUM_CLOCKS; n++) begin
            acc[n] <= '0;
          end
          if (lock_s) begin
            state <= StSettle;
          end
        end
        StSettle: begin
          if (!lock_s) begin
            state <= StUnlocked;
            cnt   <= '0;
          end else if (cnt == CntMax) begin
            state  <= StRun;
            locked <= 1'b1;
            // A load on the entry edge wins over the older shadow phase.
            for (int n = 0; n < NUM_CLOCKS; n++) begin
              acc[n] <= cfg_load ? cfg_phase[n*DIV_WIDTH +: DIV_WIDTH]
                                 : sh_phase[n*DIV_WIDTH +: DIV_WIDTH];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StRun: begin
          if (!lock_s) begin
            state     <= StUnlocked;
            cnt       <= '0;
            locked    <= 1'b0;
            outclk_en <= '0;
            outclk    <= '0;
            for (int n = 0; n < NUM_CLOCKS; n++) begin
              acc[n] <= '0;
            end
          end else begin
            for (int n = 0; n < NUM_CLOCKS; n++) begin
              acc[n]       <= sum[n][DIV_WIDTH-1:0];
              outclk_en[n] <= sum[n][DIV_WIDTH];
              if (sum[n][DIV_WIDTH]) begin
                outclk[n] <= ~outclk[n];
              end
            end
          end
        end
        default: state <= StUnlocked;
      endcase
    end
  end

endmodule
